ultra_meas_ctrl: RTL and testbench
==================================

Name: ultra_meas_ctrl

Overview:
Measurement sequencer for the HC-SR04 ultrasonic ranging path. It issues the trigger pulse, waits for the echo, and times the echo width in clock cycles. It enforces echo timeout, saturation and an inter-measurement holdoff. It sits between the user enable (board switch) and the distance-to-LED decode, replacing ad-hoc trigger and echo handling in the top level.

Parameters:
CNT_W, 22, width of the echo/holdoff counters and of echo_cycles.
TRIG_CYCLES, 250, trigger high time in clocks (10 us at 25 MHz).
TIMEOUT_CYCLES, 250000, maximum clocks in WAIT_ECHO before declaring no echo.
MAX_ECHO_CYCLES, 950000, echo-width saturation limit (~38 ms).
HOLDOFF_CYCLES, 1500000, minimum quiet time after a measurement (60 ms).

Ports:
clk_in  in  1  system clock; all state updates on its rising edge.
rst_n  in  1  asynchronous, active-low reset.
en  in  1  level enable; measurements repeat while high.
echo  in  1  asynchronous echo from sensor.
trigger  out  1  registered trigger to sensor.
busy  out  1  high in any state other than IDLE.
valid  out  1  one-cycle pulse when a result/timeout is published.
timeout  out  1  qualifies valid: 1 = no echo or saturated echo; held until the next valid.
echo_cycles  out  CNT_W  last measured echo width in clocks; held between measurements.
state_dbg  out  3  current state encoding.

Behaviour:
- Reset (async assert, sync to clk_in on release): state=IDLE, trigger=0, busy=0, valid=0, timeout=0, echo_cycles=0, all counters=0, synchronizer flops=0.
- echo passes through a 2-flop synchronizer giving echo_s, followed by a registered copy for edge detection. Both edges are delayed 2 cycles, so the measured width equals the pulse width ±1 cycle.
- IDLE: when en=1, move to TRIG; trigger goes high in the cycle after en is first sampled high.
- TRIG: trigger=1 for exactly TRIG_CYCLES cycles, then WAIT_ECHO with trigger=0 and the counter cleared.
- WAIT_ECHO:
  - A rising edge of echo_s moves to MEASURE, with the count starting at 1.
  - If echo_s is already high on entry, it is not treated as an edge; a fresh rise is required.
  - If the counter reaches TIMEOUT_CYCLES first: valid=1, timeout=1, echo_cycles unchanged, then HOLDOFF.
- MEASURE: the counter increments each cycle echo_s=1.
  - Falling edge of echo_s: echo_cycles=count, timeout=0, valid=1, then HOLDOFF.
  - If the count reaches MAX_ECHO_CYCLES: echo_cycles=MAX_ECHO_CYCLES, timeout=1, valid=1, then HOLDOFF.
- HOLDOFF: count HOLDOFF_CYCLES, then go to IDLE only if echo_s=0; otherwise remain until echo_s=0.
- en deasserted mid-sequence: the current sequence completes including HOLDOFF, then the block stays in IDLE. No partial abort.
- en held high: runs continuously, one measurement per TRIG+WAIT/MEASURE+HOLDOFF.
- valid is never high for two consecutive cycles; trigger is never high outside TRIG.
- Reset mid-operation: trigger drops immediately (async); no valid is issued.
- Arithmetic: counters are unsigned CNT_W, compared with equality/≥ against parameters. CNT_W must satisfy 2^CNT_W > max(TIMEOUT, MAX_ECHO, HOLDOFF); this is checked in simulation by an initial assertion.

Decomposition:
- Shared include ultra_defs.vh: state encodings (IDLE=0, TRIG=1, WAIT_ECHO=2, MEASURE=3, HOLDOFF=4) and default timing constants for 25 MHz.
- One sub-module: ultra_sync_edge (2-flop synchronizer plus rise/fall pulse outputs), reused later for the switch input.

Test Plan (overrides: CNT_W=12, TRIG_CYCLES=10, TIMEOUT_CYCLES=200, MAX_ECHO_CYCLES=1000, HOLDOFF_CYCLES=50):
1. Hold rst_n=0 with en=1 and echo toggling -> trigger=0, valid=0, echo_cycles=0, state_dbg=0 throughout.
2. en=1; echo high for 100 cycles starting 20 cycles after trigger falls -> trigger high exactly 10 cycles; one valid pulse; echo_cycles=100 (±1); timeout=0.
3. en=1, echo never rises -> valid pulses 200 cycles after trigger falls with timeout=1 and echo_cycles unchanged; next trigger follows ≥50 cycles later.
4. echo held high 1500 cycles -> valid with echo_cycles=1000, timeout=1; the block stays in HOLDOFF until echo falls, then retriggers.
5. en dropped during MEASURE (echo 100 cycles) -> measurement published (echo_cycles=100); after HOLDOFF, state=IDLE and no further trigger.
6. Assert rst_n=0 in the 5th TRIG cycle -> trigger falls in the same timestep; no valid; after release with en=1, a full 10-cycle trigger is issued.

Source files
------------

// File: rtl/ultra_meas_ctrl_pkg.sv
// Shared types and 25 MHz default timing for the HC-SR04 measurement sequencer.
// State encodings are fixed because they are exported on state_dbg.
package ultra_meas_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_ECHO = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_HOLDOFF   = 3'd4
    } state_e;

    localparam int DEF_CNT_W           = 22;
    localparam int DEF_TRIG_CYCLES     = 250;
    localparam int DEF_TIMEOUT_CYCLES  = 250000;
    localparam int DEF_MAX_ECHO_CYCLES = 950000;
    localparam int DEF_HOLDOFF_CYCLES  = 1500000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ultra_meas_ctrl_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, with one-cycle rise/fall
// pulses derived from a registered copy of the synchronized level.
module ultra_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[0], din};
        prev_d = sync_q[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign dout = sync_q[1];
    assign rise = sync_q[1] & ~prev_q;
    assign fall = ~sync_q[1] & prev_q;

endmodule

// File: rtl/ultra_meas_ctrl.sv
// HC-SR04 measurement sequencer: trigger pulse, echo wait with timeout,
// echo-width timing with saturation, and a quiet holdoff between shots.
module ultra_meas_ctrl
    import ultra_meas_ctrl_pkg::*;
#(
    parameter int CNT_W           = DEF_CNT_W,
    parameter int TRIG_CYCLES     = DEF_TRIG_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
    parameter int MAX_ECHO_CYCLES = DEF_MAX_ECHO_CYCLES,
    parameter int HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             echo,
    output logic             trigger,
    output logic             busy,
    output logic             valid,
    output logic             timeout,
    output logic [CNT_W-1:0] echo_cycles,
    output logic [2:0]       state_dbg
);

    if ((64'd1 << CNT_W) <= 64'(max3(TIMEOUT_CYCLES, MAX_ECHO_CYCLES, HOLDOFF_CYCLES)))
    begin : g_cnt_w_too_narrow
        $error("ultra_meas_ctrl: CNT_W cannot hold the largest timing limit");
    end

    // Counters compare against "limit - 1" so each phase lasts exactly limit cycles.
    localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_LAST     = CNT_W'(MAX_ECHO_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_ECHO     = CNT_W'(MAX_ECHO_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    logic echo_s, echo_rise, echo_fall;

    ultra_sync_edge u_echo_sync (
        .clk   (clk_in),
        .rst_n (rst_n),
        .din   (echo),
        .dout  (echo_s),
        .rise  (echo_rise),
        .fall  (echo_fall)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] echo_cycles_q, echo_cycles_d;
    logic             trigger_q, trigger_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        echo_cycles_d = echo_cycles_q;
        valid_d       = 1'b0;
        timeout_d     = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_TRIG;
                    cnt_d   = '0;
                end
            end
            ST_TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    state_d = ST_WAIT_ECHO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_ECHO: begin
                // Only a fresh rise counts; a level already high on entry never pulses.
                if (echo_rise) begin
                    state_d = ST_MEASURE;
                    cnt_d   = CNT_ONE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = ST_HOLDOFF;
                    cnt_d     = '0;
                    valid_d   = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_MEASURE: begin
                if (echo_fall) begin
                    state_d       = ST_HOLDOFF;
                    cnt_d         = '0;
                    echo_cycles_d = cnt_q;
                    valid_d       = 1'b1;
                    timeout_d     = 1'b0;
                end else if (cnt_q == MAX_LAST) begin
                    state_d       = ST_HOLDOFF;
                    cnt_d         = '0;
                    echo_cycles_d = MAX_ECHO;
                    valid_d       = 1'b1;
                    timeout_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HOLDOFF: begin
                // Counter parks at its limit while a stuck echo keeps us here.
                if (cnt_q >= HOLD_LAST) begin
                    if (!echo_s) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        trigger_d = (state_d == ST_TRIG);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            echo_cycles_q <= '0;
            trigger_q     <= 1'b0;
            busy_q        <= 1'b0;
            valid_q       <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            echo_cycles_q <= echo_cycles_d;
            trigger_q     <= trigger_d;
            busy_q        <= busy_d;
            valid_q       <= valid_d;
            timeout_q     <= timeout_d;
        end
    end

    assign trigger     = trigger_q;
    assign busy        = busy_q;
    assign valid       = valid_q;
    assign timeout     = timeout_q;
    assign echo_cycles = echo_cycles_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_ultra_meas_ctrl.sv
// Directed bench for ultra_meas_ctrl with a cycle-level behavioural model
// compared on every falling clock edge, plus hand-computed literal checks.
module tb_ultra_meas_ctrl;

    localparam int CNT_W   = 12;
    localparam int TRIG    = 10;
    localparam int TMO     = 200;
    localparam int MAXE    = 1000;
    localparam int HOLD    = 50;

    logic             clk_in = 1'b0;
    logic             rst_n  = 1'b0;
    logic             en     = 1'b0;
    logic             echo   = 1'b0;
    logic             trigger, busy, valid, timeout;
    logic [CNT_W-1:0] echo_cycles;
    logic [2:0]       state_dbg;

    int checks   = 0;
    int failures = 0;

    always #5 clk_in = ~clk_in;

    ultra_meas_ctrl #(
        .CNT_W           (CNT_W),
        .TRIG_CYCLES     (TRIG),
        .TIMEOUT_CYCLES  (TMO),
        .MAX_ECHO_CYCLES (MAXE),
        .HOLDOFF_CYCLES  (HOLD)
    ) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .en          (en),
        .echo        (echo),
        .trigger     (trigger),
        .busy        (busy),
        .valid       (valid),
        .timeout     (timeout),
        .echo_cycles (echo_cycles),
        .state_dbg   (state_dbg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d expected=[%0d..%0d] t=%0t", name, act, lo, hi, $time);
        end
    endtask

    // Behavioural model: phase numbers are the published state encodings,
    // phase lengths are tracked as plain countdowns / elapsed counts.
    int m_phase, m_left, m_wait, m_width, m_hold, m_echo;
    bit m_trig, m_valid, m_to;
    bit e1, e2, e3, es, es_prev;

    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_left = 0; m_wait = 0; m_width = 0; m_hold = 0; m_echo = 0;
            m_trig = 0; m_valid = 0; m_to = 0;
            e1 = 0; e2 = 0; e3 = 0;
        end else begin
            es = e2;
            es_prev = e3;
            m_valid = 0;
            case (m_phase)
                0: if (en) begin m_phase = 1; m_left = TRIG; end
                1: begin
                    m_left--;
                    if (m_left == 0) begin m_phase = 2; m_wait = 0; end
                end
                2: begin
                    m_wait++;
                    if (es && !es_prev) begin
                        m_phase = 3; m_width = 1;
                    end else if (m_wait == TMO) begin
                        m_valid = 1; m_to = 1; m_phase = 4; m_hold = 0;
                    end
                end
                3: begin
                    if (!es) begin
                        m_echo = m_width; m_to = 0; m_valid = 1; m_phase = 4; m_hold = 0;
                    end else begin
                        m_width++;
                        if (m_width == MAXE) begin
                            m_echo = MAXE; m_to = 1; m_valid = 1; m_phase = 4; m_hold = 0;
                        end
                    end
                end
                default: begin
                    m_hold++;
                    if (m_hold >= HOLD && !es) m_phase = 0;
                end
            endcase
            m_trig = (m_phase == 1);
            e3 = e2; e2 = e1; e1 = echo;
        end
    end

    // Monitors: cycle count, trigger run length, valid pulses, trigger rises.
    int  cyc = 0, trig_run = 0, last_trig_len = 0, valid_cnt = 0, trig_rises = 0;
    logic trig_prev = 1'b0, valid_prev = 1'b0;

    always @(posedge clk_in) cyc++;

    always @(negedge clk_in) begin
        check("cmp_trigger", 32'(trigger), 32'(m_trig));
        check("cmp_valid", 32'(valid), 32'(m_valid));
        check("cmp_timeout", 32'(timeout), 32'(m_to));
        check("cmp_echo_cycles", 32'(echo_cycles), m_echo);
        check("cmp_busy", 32'(busy), 32'(m_phase != 0));
        check("cmp_state", 32'(state_dbg), m_phase);
        if (valid && valid_prev) check("valid_back_to_back", 32'(valid_prev & valid), 0);
        if (trigger) trig_run++;
        else if (trig_run != 0) begin last_trig_len = trig_run; trig_run = 0; end
        if (trigger && !trig_prev) trig_rises++;
        if (valid) valid_cnt++;
        trig_prev  = trigger;
        valid_prev = valid;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #2;
    endtask

    task automatic wait_trig(input logic lvl, input int bound, input string name);
        int n = 0;
        while (trigger !== lvl && n < bound) begin step(1); n++; end
        check(name, 32'(trigger), 32'(lvl));
    endtask

    task automatic wait_valid(input int bound, input string name);
        int n = 0;
        while (valid !== 1'b1 && n < bound) begin step(1); n++; end
        check(name, 32'(valid), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, vcnt, rises;

        // 1: reset held with en high and echo toggling
        rst_n = 1'b0; en = 1'b1; echo = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            echo = 1'($urandom_range(0, 1));
        end
        echo = 1'b0;
        check("rst_trigger", 32'(trigger), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_echo_cycles", 32'(echo_cycles), 0);
        check("rst_state", 32'(state_dbg), 0);
        step(3);
        rst_n = 1'b1;

        // 2: 100-cycle echo starting 20 cycles after trigger falls
        vcnt = valid_cnt;
        wait_trig(1'b1, 5, "t2_trig_rise");
        wait_trig(1'b0, 15, "t2_trig_fall");
        step(20);
        echo = 1'b1;
        step(100);
        echo = 1'b0;
        wait_valid(10, "t2_valid");
        check("t2_trig_len", last_trig_len, 10);
        check_range("t2_echo_cycles", int'(echo_cycles), 99, 101);
        check("t2_model_echo", m_echo, 100);
        check("t2_timeout", 32'(timeout), 0);
        step(2);
        check("t2_one_valid", valid_cnt - vcnt, 1);

        // 3: no echo -> timeout 200 cycles after trigger falls
        wait_trig(1'b1, 80, "t3_trig_rise");
        wait_trig(1'b0, 15, "t3_trig_fall");
        t0 = cyc;
        wait_valid(220, "t3_valid");
        check("t3_timeout_delay", cyc - t0, 200);
        check("t3_timeout", 32'(timeout), 1);
        check_range("t3_echo_held", int'(echo_cycles), 99, 101);
        t1 = cyc;
        wait_trig(1'b1, 80, "t3_next_trig");
        check_range("t3_holdoff_gap", cyc - t1, 50, 80);

        // 4: echo stuck high 1500 cycles -> saturation, stay in holdoff
        wait_trig(1'b0, 15, "t4_trig_fall");
        step(5);
        echo = 1'b1;
        t0 = cyc;
        wait_valid(1100, "t4_valid");
        check("t4_echo_sat", 32'(echo_cycles), 1000);
        check("t4_model_sat", m_echo, 1000);
        check("t4_timeout", 32'(timeout), 1);
        step(100);
        check("t4_held_holdoff", 32'(state_dbg), 4);
        check("t4_no_trig", 32'(trigger), 0);
        step(1500 - (cyc - t0));
        echo = 1'b0;
        wait_trig(1'b1, 20, "t4_retrigger");

        // 5: en dropped mid-measurement; result still published, then idle
        wait_trig(1'b0, 15, "t5_trig_fall");
        step(10);
        echo = 1'b1;
        step(50);
        en = 1'b0;
        step(50);
        echo = 1'b0;
        wait_valid(10, "t5_valid");
        check_range("t5_echo_cycles", int'(echo_cycles), 99, 101);
        check("t5_timeout", 32'(timeout), 0);
        step(60);
        check("t5_idle_state", 32'(state_dbg), 0);
        check("t5_idle_busy", 32'(busy), 0);
        rises = trig_rises;
        step(100);
        check("t5_no_retrigger", trig_rises - rises, 0);

        // 6: reset in the 5th trigger cycle
        en = 1'b1;
        wait_trig(1'b1, 5, "t6_trig_rise");
        step(4);
        vcnt = valid_cnt;
        rst_n = 1'b0;
        #1;
        check("t6_async_trig_drop", 32'(trigger), 0);
        check("t6_async_state", 32'(state_dbg), 0);
        step(3);
        rst_n = 1'b1;
        wait_trig(1'b1, 5, "t6_trig_after_rst");
        wait_trig(1'b0, 15, "t6_trig_fall");
        @(negedge clk_in);
        #1;
        check("t6_trig_len", last_trig_len, 10);
        check("t6_no_valid", valid_cnt - vcnt, 0);

        en = 1'b0;
        step(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
